// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: drives the PC to instruction memory and queues
// {pc, instruction} pairs in a small FIFO toward decode; redirects flush it.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] instructionAddress,
    input  logic [31:0] instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc,
    output logic        misaligned_fault
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    // Handshake: an entry leaves the head on any rising edge where
    // out_valid && out_ready, unless a redirect on that same edge discards it.

    state_t        state, state_next;
    logic [31:0]   pc, pc_next;
    logic [CW-1:0] count, count_next;
    logic [PW-1:0] rd_ptr, rd_ptr_next;
    logic [PW-1:0] wr_ptr, wr_ptr_next;
    logic          push, pop;

    logic [31:0] buf_pc    [DEPTH];
    logic [31:0] buf_instr [DEPTH];

    assign instructionAddress = pc;
    assign out_valid          = (count != '0);
    assign out_pc             = out_valid ? buf_pc[rd_ptr]    : 32'h0;
    assign out_instruction    = out_valid ? buf_instr[rd_ptr] : 32'h0;
    assign misaligned_fault   = (state == FAULT);

    always_comb begin
        pop  = out_valid && out_ready;
        push = (state == RUN) && !redirect_valid && ((count < DEPTH_C) || pop);

        state_next  = state;
        pc_next     = pc;
        count_next  = count;
        rd_ptr_next = rd_ptr;
        wr_ptr_next = wr_ptr;

        if (redirect_valid) begin
            // Flush everything; a misaligned target parks the unit in FAULT
            // until a later aligned redirect.
            pc_next     = redirect_target;
            count_next  = '0;
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            state_next  = (redirect_target[1:0] != 2'b00) ? FAULT : RUN;
        end else begin
            if (push) begin
                pc_next     = pc + 32'd4;
                wr_ptr_next = wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_next = count + CW'(1);
                2'b01:   count_next = count - CW'(1);
                default: count_next = count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            pc     <= RESET_PC;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            state  <= state_next;
            pc     <= pc_next;
            count  <= count_next;
            rd_ptr <= rd_ptr_next;
            wr_ptr <= wr_ptr_next;
        end
    end

    // Payload storage needs no reset; count gates visibility of stale entries.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[wr_ptr]    <= pc;
            buf_instr[wr_ptr] <= instruction;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: streaming, backpressure,
// redirects, misaligned faults, PC wrap and asynchronous reset.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] PAT      = 32'hC0DE_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] instructionAddress;
    logic [31:0] instruction;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic        misaligned_fault;

    int checks = 0;
    int errors = 0;

    instruction_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .instructionAddress (instructionAddress),
        .instruction        (instruction),
        .redirect_valid     (redirect_valid),
        .redirect_target    (redirect_target),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_instruction    (out_instruction),
        .out_pc             (out_pc),
        .misaligned_fault   (misaligned_fault)
    );

    // Clock/reset: 10 ns period, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word at address A is A ^ PAT.
    assign instruction = instructionAddress ^ PAT;

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect_valid  = 1'b1;
        redirect_target = target;
        @(negedge clk);
        redirect_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'h0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instruction !== 32'h0) begin
            errors++;
            $display("FAIL reset_head: valid=%b pc=%h instr=%h, required 0/0/0", out_valid, out_pc, out_instruction);
        end
        checks++;
        if (instructionAddress !== RESET_PC || misaligned_fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_pc: addr=%h fault=%b, required %h/0", instructionAddress, misaligned_fault, RESET_PC);
        end
    endtask

    task automatic test_stream();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * i) || out_instruction !== (32'(4 * i) ^ PAT)) begin
                errors++;
                $display("FAIL stream[%0d]: valid=%b pc=%h instr=%h, required 1/%h/%h", i, out_valid, out_pc, out_instruction, 32'(4 * i), 32'(4 * i) ^ PAT);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_addr;
        do_reset();
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            exp_addr = (k < DEPTH) ? 32'(4 * k) : 32'(4 * DEPTH);
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'h0 || instructionAddress !== exp_addr) begin
                errors++;
                $display("FAIL backpressure[%0d]: valid=%b head=%h addr=%h, required 1/0/%h", k, out_valid, out_pc, instructionAddress, exp_addr);
            end
        end
        out_ready = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * j) || out_instruction !== (32'(4 * j) ^ PAT)) begin
                errors++;
                $display("FAIL drain[%0d]: valid=%b pc=%h instr=%h, required 1/%h", j, out_valid, out_pc, out_instruction, 32'(4 * j));
            end
        end
    endtask

    task automatic test_redirect_full();
        do_reset();
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
        do_redirect(32'h0000_0100);
        checks++;
        if (out_valid !== 1'b0 || instructionAddress !== 32'h100 || misaligned_fault !== 1'b0) begin
            errors++;
            $display("FAIL redirect_flush: valid=%b addr=%h fault=%b, required 0/100/0", out_valid, instructionAddress, misaligned_fault);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instruction !== (32'h100 ^ PAT)) begin
            errors++;
            $display("FAIL redirect_target: valid=%b pc=%h instr=%h, required 1/100/%h", out_valid, out_pc, out_instruction, 32'h100 ^ PAT);
        end
    endtask

    task automatic test_misaligned();
        do_reset();
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        do_redirect(32'h0000_0102);
        checks++;
        if (misaligned_fault !== 1'b1 || out_valid !== 1'b0 || instructionAddress !== 32'h102) begin
            errors++;
            $display("FAIL fault_enter: fault=%b valid=%b addr=%h, required 1/0/102", misaligned_fault, out_valid, instructionAddress);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || misaligned_fault !== 1'b1 || instructionAddress !== 32'h102) begin
                errors++;
                $display("FAIL fault_hold[%0d]: valid=%b fault=%b addr=%h, required 0/1/102", i, out_valid, misaligned_fault, instructionAddress);
            end
        end
        do_redirect(32'h0000_0106);
        checks++;
        if (misaligned_fault !== 1'b1 || out_valid !== 1'b0 || instructionAddress !== 32'h106) begin
            errors++;
            $display("FAIL fault_refault: fault=%b valid=%b addr=%h, required 1/0/106", misaligned_fault, out_valid, instructionAddress);
        end
        do_redirect(32'h0000_0200);
        checks++;
        if (misaligned_fault !== 1'b0 || out_valid !== 1'b0 || instructionAddress !== 32'h200) begin
            errors++;
            $display("FAIL fault_clear: fault=%b valid=%b addr=%h, required 0/0/200", misaligned_fault, out_valid, instructionAddress);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h200) begin
            errors++;
            $display("FAIL fault_resume: valid=%b pc=%h, required 1/200", out_valid, out_pc);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc;
        do_reset();
        out_ready = 1'b1;
        do_redirect(32'hFFFF_FFF8);
        checks++;
        if (out_valid !== 1'b0 || instructionAddress !== 32'hFFFF_FFF8) begin
            errors++;
            $display("FAIL wrap_redirect: valid=%b addr=%h, required 0/fffffff8", out_valid, instructionAddress);
        end
        exp_pc = 32'hFFFF_FFF8;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instruction !== (exp_pc ^ PAT)) begin
                errors++;
                $display("FAIL wrap[%0d]: valid=%b pc=%h instr=%h, required 1/%h", i, out_valid, out_pc, out_instruction, exp_pc);
            end
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || instructionAddress !== 32'h8) begin
            errors++;
            $display("FAIL async_prefill: valid=%b addr=%h, required 1/8", out_valid, instructionAddress);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || instructionAddress !== RESET_PC || out_pc !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: valid=%b addr=%h pc=%h, required 0/%h/0", out_valid, instructionAddress, out_pc, RESET_PC);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_redirect(32'h0000_0001);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (misaligned_fault !== 1'b0 || instructionAddress !== RESET_PC) begin
            errors++;
            $display("FAIL async_fault_reset: fault=%b addr=%h, required 0/%h", misaligned_fault, instructionAddress, RESET_PC);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== RESET_PC || instructionAddress !== (RESET_PC + 32'd4)) begin
            errors++;
            $display("FAIL first_push: valid=%b pc=%h addr=%h, required 1/%h/%h", out_valid, out_pc, instructionAddress, RESET_PC, RESET_PC + 32'd4);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_misaligned();
        test_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the fetch address loaded at reset.
REQ-002 The module SHALL have parameter DEPTH, default 2, meaning the fetch-buffer entry count (legal values 2 and 4).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port instructionAddress, output, 32 bits: the current PC, driven to the instruction memory.
REQ-006 The module SHALL have port instruction, input, 32 bits: the combinational memory read data for instructionAddress.
REQ-007 The module SHALL have port redirect_valid, input, 1 bit: a branch/jump redirect request from execute.
REQ-008 The module SHALL have port redirect_target, input, 32 bits: the new PC for the redirect.
REQ-009 The module SHALL have port out_valid, output, 1 bit: the buffer head holds a valid instruction.
REQ-010 The module SHALL have port out_ready, input, 1 bit: the decode stage accepts the head this cycle.
REQ-011 The module SHALL have port out_instruction, output, 32 bits: the head instruction word.
REQ-012 The module SHALL have port out_pc, output, 32 bits: the PC of the head instruction.
REQ-013 The module SHALL have port misaligned_fault, output, 1 bit: sticky fault flag for a redirect target not 4-byte aligned.

Function
REQ-014 instructionAddress SHALL equal the PC register combinationally; memory data is sampled in the same cycle.
REQ-015 The fetch buffer SHALL be a DEPTH-entry FIFO of {pc, instruction} pairs with a count from 0 to DEPTH.
REQ-016 pop SHALL occur when out_valid && out_ready.
REQ-017 push SHALL occur when state==RUN && !redirect_valid && (count<DEPTH || pop).
REQ-018 A push SHALL write {PC, instruction} at the tail and set PC <= PC + 32'd4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000).
REQ-019 When no push occurs, the PC SHALL hold its value.
REQ-020 Simultaneous push and pop SHALL leave count unchanged, including when count==DEPTH.
REQ-021 out_valid SHALL equal (count != 0); out_instruction/out_pc SHALL show the head entry, or 32'h0 when count==0.
REQ-022 Fetch-to-decode latency SHALL be one cycle: an instruction pushed at edge N is visible at the head after edge N when the buffer was empty.
REQ-023 Head outputs SHALL remain stable while out_valid && !out_ready (no redirect).
REQ-024 redirect_valid SHALL have highest priority: at that edge count <= 0, PC <= redirect_target, no push, and any pop is discarded.
REQ-025 out_valid SHALL be 0 in the cycle after a redirect edge.
REQ-026 The state machine SHALL have states RUN and FAULT.
REQ-027 RUN -> FAULT SHALL occur on a redirect with redirect_target[1:0] != 0; PC is still loaded with the target.
REQ-028 FAULT -> RUN SHALL occur on a redirect with an aligned target; FAULT + misaligned redirect SHALL stay in FAULT with PC updated.
REQ-029 In FAULT: no pushes; entries already buffered are none (flushed by the redirect); misaligned_fault = 1.
REQ-030 misaligned_fault SHALL equal (state==FAULT), registered.

Reset
REQ-031 When rst_n==0, the following SHALL apply immediately (asynchronously): PC=RESET_PC, count=0, state=RUN, out_valid=0, out_instruction=0, out_pc=0, misaligned_fault=0.
REQ-032 Reset asserted mid-operation SHALL discard all buffered entries with no partial push.
REQ-033 The first push SHALL occur at the first rising edge with rst_n==1.

Verification
REQ-034 Scenario (reset/stream): release reset, memory word = address pattern, out_ready=1 -> out_pc sequence 0,4,8,... with out_valid=1 from the cycle after the first edge, one instruction per cycle.
REQ-035 Scenario (backpressure): out_ready=0 for 5 cycles -> count saturates at DEPTH, PC stops at 4*DEPTH, and the head stays at pc 0; on out_ready=1, pops proceed in order with no loss or duplication.
REQ-036 Scenario (redirect while full): DEPTH entries buffered, redirect_target=32'h0000_0100 -> next cycle out_valid=0, instructionAddress=0x100; the following cycle out_pc=0x100.
REQ-037 Scenario (misaligned redirect): redirect_target=32'h0000_0102 -> misaligned_fault=1, out_valid stays 0 for 10 cycles; a later redirect to 0x200 clears the fault, and the next cycle out_pc=0x200.
REQ-038 Scenario (wrap): redirect to 32'hFFFF_FFF8, out_ready=1 -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-039 Scenario (async reset): assert rst_n=0 between edges with 2 entries buffered -> out_valid=0 and instructionAddress=RESET_PC before the next clock edge.
